idex_stage_reg: RTL and testbench



---
 rtl/idex_stage_reg_pkg.sv | 30 +++
 rtl/idex_stage_reg_if.sv | 41 ++++
 rtl/idex_stage_reg_skid_buf.sv | 71 +++++++
 rtl/idex_stage_reg.sv | 97 +++++++++
 tb/tb_idex_stage_reg.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/idex_stage_reg_pkg.sv
// Shared definitions for the ID/EX stage register: default field widths,
// the packed decode payload and the skid-buffer state encoding.
package idex_stage_reg_pkg;

   localparam int IDEX_WB_W   = 2;
   localparam int IDEX_M_W    = 2;
   localparam int IDEX_EX_W   = 4;
   localparam int IDEX_DATA_W = 32;
   localparam int IDEX_REG_W  = 5;

   // Everything carried from ID to EX, packed so storage is one vector.
   typedef struct packed {
      logic [IDEX_WB_W-1:0]   wb;
      logic [IDEX_M_W-1:0]    m;
      logic [IDEX_EX_W-1:0]   ex;
      logic [IDEX_DATA_W-1:0] pc;
      logic [IDEX_DATA_W-1:0] data1;
      logic [IDEX_DATA_W-1:0] data2;
      logic [IDEX_DATA_W-1:0] signextend;
      logic [IDEX_REG_W-1:0]  rs;
      logic [IDEX_REG_W-1:0]  rt;
      logic [IDEX_REG_W-1:0]  rd;
   } idex_payload_t;

   // Skid-buffer occupancy: output register only, or output plus skid entry.
   localparam logic [1:0] SKID_EMPTY = 2'd0;
   localparam logic [1:0] SKID_ONE   = 2'd1;
   localparam logic [1:0] SKID_TWO   = 2'd2;

endpackage

// File: rtl/idex_stage_reg_if.sv
// ID/EX handshake and field bundle. The stage register uses the slave view;
// the surrounding pipeline (decode on one side, EX on the other) uses master.
interface idex_stage_reg_if
   import idex_stage_reg_pkg::*;
#(
   parameter int WB_W   = IDEX_WB_W,
   parameter int M_W    = IDEX_M_W,
   parameter int EX_W   = IDEX_EX_W,
   parameter int DATA_W = IDEX_DATA_W,
   parameter int REG_W  = IDEX_REG_W
) ();
   logic              flush_i;
   logic              valid_i;
   logic              ready_o;
   logic [WB_W-1:0]   WB_i;
   logic [M_W-1:0]    M_i;
   logic [EX_W-1:0]   EX_i;
   logic [DATA_W-1:0] pc_i, data1_i, data2_i, signextend_i;
   logic [REG_W-1:0]  rs_i, rt_i, rd_i;
   logic              valid_o;
   logic              ready_i;
   logic [WB_W-1:0]   WB_o;
   logic [M_W-1:0]    M_o;
   logic [EX_W-1:0]   EX_o;
   logic [DATA_W-1:0] pc_o, data1_o, data2_o, signextend_o;
   logic [REG_W-1:0]  rs_o, rt_o, rd_o;

   modport slave (
      input  flush_i, valid_i, WB_i, M_i, EX_i, pc_i, data1_i, data2_i,
             signextend_i, rs_i, rt_i, rd_i, ready_i,
      output ready_o, valid_o, WB_o, M_o, EX_o, pc_o, data1_o, data2_o,
             signextend_o, rs_o, rt_o, rd_o
   );

   modport master (
      output flush_i, valid_i, WB_i, M_i, EX_i, pc_i, data1_i, data2_i,
             signextend_i, rs_i, rt_i, rd_i, ready_i,
      input  ready_o, valid_o, WB_o, M_o, EX_o, pc_o, data1_o, data2_o,
             signextend_o, rs_o, rt_o, rd_o
   );
endinterface

// File: rtl/idex_stage_reg_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The output register always holds
// the oldest entry; the skid entry catches one word when the sink stalls, so
// ready can come straight from a flop.
module pipe_skid_buf
   import idex_stage_reg_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_clr,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data
);
   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [DATA_W-1:0] r_out;
   logic [DATA_W-1:0] r_skid;
   logic              r_ready;
   logic              w_accept;
   logic              w_consume;

   assign o_valid   = (r_state != SKID_EMPTY);
   assign o_ready   = r_ready;
   assign o_data    = r_out;
   assign w_accept  = i_valid & r_ready;
   assign w_consume = o_valid & i_ready;

   // Occupancy transition from the two handshakes.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SKID_EMPTY: if (w_accept) w_state_next = SKID_ONE;
         SKID_ONE: begin
            if (w_accept && !w_consume)      w_state_next = SKID_TWO;
            else if (!w_accept && w_consume) w_state_next = SKID_EMPTY;
         end
         SKID_TWO:   if (w_consume) w_state_next = SKID_ONE;
         default:    w_state_next = SKID_EMPTY;
      endcase
   end

   // State, registered ready and the two data entries; clear drops both entries.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= SKID_EMPTY;
         r_ready <= 1'b1;
         r_out   <= '0;
         r_skid  <= '0;
      end else if (i_clr) begin
         r_state <= SKID_EMPTY;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_ready <= (w_state_next != SKID_TWO);
         case (r_state)
            SKID_EMPTY: if (w_accept) r_out <= i_data;
            SKID_ONE: begin
               if (w_accept && w_consume) r_out  <= i_data;
               else if (w_accept)         r_skid <= i_data;
            end
            SKID_TWO:   if (w_consume) r_out <= r_skid;
            default:    ;
         endcase
      end
   end
endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline stage register with valid/ready handshake, synchronous flush
// and an optional skid buffer. Control fields read zero whenever no
// instruction is valid, so a bubble never carries live write/memory enables.
module idex_stage_reg
   import idex_stage_reg_pkg::*;
#(
   parameter int WB_W   = IDEX_WB_W,
   parameter int M_W    = IDEX_M_W,
   parameter int EX_W   = IDEX_EX_W,
   parameter int DATA_W = IDEX_DATA_W,
   parameter int REG_W  = IDEX_REG_W,
   parameter int SKID   = 1
) (
   input logic          clk_i,
   input logic          rst_i,
   idex_stage_reg_if.slave bus
);
   // Same layout as idex_payload_t but sized by this instance's parameters.
   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [M_W-1:0]    m;
      logic [EX_W-1:0]   ex;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
      logic [DATA_W-1:0] signextend;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
   } pl_t;
   localparam int PL_W = $bits(pl_t);

   pl_t  w_pl_in;
   pl_t  w_pl_out;
   logic w_valid;
   logic w_ready;

   assign w_pl_in = {bus.WB_i, bus.M_i, bus.EX_i, bus.pc_i, bus.data1_i,
                     bus.data2_i, bus.signextend_i, bus.rs_i, bus.rt_i, bus.rd_i};

   generate
      if (SKID != 0) begin : g_skid
         logic [PL_W-1:0] w_out;
         pipe_skid_buf #(.DATA_W(PL_W)) u_skid (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_clr   (bus.flush_i),
            .i_valid (bus.valid_i),
            .o_ready (w_ready),
            .i_data  (w_pl_in),
            .o_valid (w_valid),
            .i_ready (bus.ready_i),
            .o_data  (w_out)
         );
         assign w_pl_out = w_out;
      end else begin : g_reg
         logic r_valid;
         pl_t  r_pl;
         logic w_accept;
         logic w_consume;

         assign w_ready   = bus.ready_i | ~r_valid;
         assign w_accept  = bus.valid_i & w_ready;
         assign w_consume = r_valid & bus.ready_i;
         assign w_valid   = r_valid;
         assign w_pl_out  = r_pl;

         // Single output register; flush kills the held and the incoming word.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_valid <= 1'b0;
               r_pl    <= '0;
            end else if (bus.flush_i) begin
               r_valid <= 1'b0;
            end else if (w_accept) begin
               r_valid <= 1'b1;
               r_pl    <= w_pl_in;
            end else if (w_consume) begin
               r_valid <= 1'b0;
            end
         end
      end
   endgenerate

   assign bus.ready_o      = w_ready;
   assign bus.valid_o      = w_valid;
   assign bus.WB_o         = w_valid ? w_pl_out.wb : '0;
   assign bus.M_o          = w_valid ? w_pl_out.m  : '0;
   assign bus.EX_o         = w_valid ? w_pl_out.ex : '0;
   assign bus.pc_o         = w_pl_out.pc;
   assign bus.data1_o      = w_pl_out.data1;
   assign bus.data2_o      = w_pl_out.data2;
   assign bus.signextend_o = w_pl_out.signextend;
   assign bus.rs_o         = w_pl_out.rs;
   assign bus.rt_o         = w_pl_out.rt;
   assign bus.rd_o         = w_pl_out.rd;
endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: one instance per SKID setting driven by the same
// stimulus, each checked against a FIFO-occupancy model of the stage.
module tb_idex_stage_reg;
   import idex_stage_reg_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   idex_stage_reg_if if0 ();
   idex_stage_reg_if if1 ();

   idex_stage_reg #(.SKID(0)) u_dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0));
   idex_stage_reg #(.SKID(1)) u_dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1));

   int tests  = 0;
   int failed = 0;

   idex_payload_t q0[$];
   idex_payload_t q1[$];

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic idex_payload_t rand_pl();
      idex_payload_t p;
      p.wb = 2'($urandom); p.m = 2'($urandom); p.ex = 4'($urandom);
      p.pc = $urandom; p.data1 = $urandom; p.data2 = $urandom;
      p.signextend = $urandom;
      p.rs = 5'($urandom); p.rt = 5'($urandom); p.rd = 5'($urandom);
      return p;
   endfunction

   function automatic idex_payload_t obs_pl(input int which);
      if (which == 0)
         return {if0.WB_o, if0.M_o, if0.EX_o, if0.pc_o, if0.data1_o, if0.data2_o,
                 if0.signextend_o, if0.rs_o, if0.rt_o, if0.rd_o};
      return {if1.WB_o, if1.M_o, if1.EX_o, if1.pc_o, if1.data1_o, if1.data2_o,
              if1.signextend_o, if1.rs_o, if1.rt_o, if1.rd_o};
   endfunction

   // Compare one instance against its model queue (occupancy = queue size).
   task automatic check_dut(input int which, input bit rdy);
      int            occ;
      bit            exp_ready;
      logic          v_obs, r_obs;
      idex_payload_t o;
      occ   = (which == 0) ? q0.size() : q1.size();
      v_obs = (which == 0) ? if0.valid_o : if1.valid_o;
      r_obs = (which == 0) ? if0.ready_o : if1.ready_o;
      exp_ready = (which == 0) ? (rdy || occ == 0) : (occ < 2);
      o = obs_pl(which);
      chk($sformatf("skid%0d.valid_o", which), 160'(v_obs), 160'(occ > 0));
      chk($sformatf("skid%0d.ready_o", which), 160'(r_obs), 160'(exp_ready));
      if (occ > 0)
         chk($sformatf("skid%0d.head", which), 160'(o),
             160'((which == 0) ? q0[0] : q1[0]));
      else
         chk($sformatf("skid%0d.bubble_ctrl", which), 160'({o.wb, o.m, o.ex}), 160'(0));
   endtask

   task automatic drive(input bit v, input bit rdy, input bit fl, input idex_payload_t p);
      if0.valid_i = v;  if1.valid_i = v;
      if0.ready_i = rdy; if1.ready_i = rdy;
      if0.flush_i = fl; if1.flush_i = fl;
      {if0.WB_i, if0.M_i, if0.EX_i, if0.pc_i, if0.data1_i, if0.data2_i,
       if0.signextend_i, if0.rs_i, if0.rt_i, if0.rd_i} = p;
      {if1.WB_i, if1.M_i, if1.EX_i, if1.pc_i, if1.data1_i, if1.data2_i,
       if1.signextend_i, if1.rs_i, if1.rt_i, if1.rd_i} = p;
   endtask

   // One clock: drive, check at the falling edge, advance the model, clock.
   task automatic cycle(input bit v, input bit rdy, input bit fl, input bit rs,
                        input idex_payload_t p);
      bit acc0, acc1;
      rst_i = rs;
      drive(v, rdy, fl, p);
      @(negedge clk_i);
      if (!rs) begin
         check_dut(0, rdy);
         check_dut(1, rdy);
      end
      if (rs || fl) begin
         q0.delete();
         q1.delete();
      end else begin
         acc0 = v && (rdy || q0.size() == 0);
         acc1 = v && (q1.size() < 2);
         if (rdy && q0.size() > 0) void'(q0.pop_front());
         if (rdy && q1.size() > 0) void'(q1.pop_front());
         if (acc0) q0.push_back(p);
         if (acc1) q1.push_back(p);
      end
      @(posedge clk_i);
      #1;
   endtask

   function automatic idex_payload_t pc_pl(input logic [31:0] pc);
      idex_payload_t p;
      p = rand_pl();
      p.pc = pc;
      return p;
   endfunction

   initial begin
      idex_payload_t p;
      drive(1'b0, 1'b1, 1'b0, '0);
      @(posedge clk_i);
      #1;

      // Reset held two cycles with valid_i asserted.
      cycle(1, 1, 0, 1, pc_pl(32'h100));
      cycle(1, 1, 0, 1, pc_pl(32'h104));
      chk("rst.valid_o0", 160'(if0.valid_o), 160'(0));
      chk("rst.valid_o1", 160'(if1.valid_o), 160'(0));
      chk("rst.EX_o0",    160'(if0.EX_o),    160'(0));
      chk("rst.EX_o1",    160'(if1.EX_o),    160'(0));
      chk("rst.data1_o0", 160'(if0.data1_o), 160'(0));
      chk("rst.data1_o1", 160'(if1.data1_o), 160'(0));

      // Streaming, then drain.
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, pc_pl(32'(i * 4)));
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, rand_pl());

      // Stall with EX held off, then release with 0x18 still presented.
      cycle(1, 0, 0, 0, pc_pl(32'h10));
      cycle(1, 0, 0, 0, pc_pl(32'h14));
      p = pc_pl(32'h18);
      cycle(1, 0, 0, 0, p);
      cycle(1, 1, 0, 0, p);
      cycle(1, 1, 0, 0, p);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, rand_pl());

      // Fill, then flush with a live instruction at ID.
      cycle(1, 0, 0, 0, pc_pl(32'h20));
      cycle(1, 0, 0, 0, pc_pl(32'h24));
      cycle(1, 0, 1, 0, pc_pl(32'h28));
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, rand_pl());

      // Simultaneous accept and consume with alternating EX control.
      for (int i = 0; i < 8; i++) begin
         p = rand_pl();
         p.ex = (i % 2 == 0) ? 4'hA : 4'h5;
         cycle(1, 1, 0, 0, p);
      end
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, rand_pl());

      // Random handshake traffic with occasional flushes.
      for (int i = 0; i < 10000; i++)
         cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0), 0, rand_pl());
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, rand_pl());

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
